fifo_rd_unpacker: RTL and testbench

Read-side drain stage that sits directly downstream of the asynchronous FIFO, in the read clock domain. It pulls DATA_W-bit words from the FIFO read port and emits them as a byte stream on a valid/ready interface. A 2-entry word buffer with read-credit tracking gives sustained one-byte-per-cycle throughput under backpressure, with no lost or duplicated data.

---
 rtl/fifo_rd_unpacker_if.sv | 33 +++
 rtl/fifo_rd_unpacker.sv | 106 ++++++++++
 tb/tb_fifo_rd_unpacker.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_unpacker_if.sv
// FIFO read port plus byte-stream output of the read-side unpacker.
// master = unpacker side, slave = FIFO/downstream side.
interface fifo_rd_unpacker_if #(
    parameter int DATA_W = 24
);
    logic              fifo_empty;
    logic              fifo_r_enable;
    logic [DATA_W-1:0] fifo_r_data;
    logic [7:0]        out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    modport master (
        input  fifo_empty,
        input  fifo_r_data,
        input  out_ready,
        output fifo_r_enable,
        output out_data,
        output out_valid,
        output out_last
    );

    modport slave (
        output fifo_empty,
        output fifo_r_data,
        output out_ready,
        input  fifo_r_enable,
        input  out_data,
        input  out_valid,
        input  out_last
    );
endinterface

// File: rtl/fifo_rd_unpacker.sv
// Drains DATA_W-bit FIFO words into a byte stream; UNPACKER_MSB_FIRST_EN selects MSB-first byte order.
// Latency: 2 cycles from fifo_r_enable to the first out_valid byte, then one byte per cycle.
// Backpressure: 2-word buffer with read credits; reads stop when buffered + in-flight words reach 2.
module fifo_rd_unpacker #(
    parameter int DATA_W = 24,
    parameter int CNT_W  = 16
) (
    input  logic                  r_clk,
    input  logic                  r_rst,
    fifo_rd_unpacker_if.master    bus,
    output logic [CNT_W-1:0]      word_cnt,
    output logic                  busy
);
    localparam int               NBYTES   = DATA_W / 8;
    localparam int               IDX_W    = $clog2(NBYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    if ((DATA_W % 8) != 0 || DATA_W < 16) begin : g_bad_width
        $error("fifo_rd_unpacker: DATA_W must be a multiple of 8 and at least 16");
    end

    logic [DATA_W-1:0] wbuf_q [2];
    logic              head_q;
    logic              tail_q;
    logic [1:0]        occ_q;
    logic              inflight_q;
    logic [IDX_W-1:0]  idx_q;
    logic [CNT_W-1:0]  word_cnt_q;

    logic [1:0]        pending;
    logic              rd_en;
    logic              capture;
    logic              out_vld;
    logic              xfer;
    logic              pop;
    logic [DATA_W-1:0] head_word;
    logic [7:0]        head_byte;

    // A read is only issued when a buffer slot is guaranteed for its data.
    assign pending = occ_q + {1'b0, inflight_q};
    assign rd_en   = !r_rst && !bus.fifo_empty && (pending < 2'd2);
    assign capture = inflight_q;
    assign out_vld = (occ_q != 2'd0);
    assign xfer    = out_vld && bus.out_ready;
    assign pop     = xfer && (idx_q == LAST_IDX);

    assign head_word = wbuf_q[head_q];

    always_comb begin
        head_byte = '0;
        for (int b = 0; b < NBYTES; b++) begin
            if (idx_q == IDX_W'(b)) begin
`ifdef UNPACKER_MSB_FIRST_EN
                head_byte = head_word[DATA_W-8-8*b +: 8];
`else
                head_byte = head_word[8*b +: 8];
`endif
            end
        end
    end

    always_ff @(posedge r_clk) begin
        if (r_rst) begin
            wbuf_q[0]  <= '0;
            wbuf_q[1]  <= '0;
            head_q     <= 1'b0;
            tail_q     <= 1'b0;
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            idx_q      <= '0;
            word_cnt_q <= '0;
        end else begin
            inflight_q <= rd_en;
            if (capture) begin
                wbuf_q[tail_q] <= bus.fifo_r_data;
                tail_q         <= ~tail_q;
            end
            if (xfer) begin
                if (pop) begin
                    idx_q      <= '0;
                    head_q     <= ~head_q;
                    word_cnt_q <= word_cnt_q + CNT_W'(1);
                end else begin
                    idx_q <= idx_q + IDX_W'(1);
                end
            end
            case ({capture, pop})
                2'b10:   occ_q <= occ_q + 2'd1;
                2'b01:   occ_q <= occ_q - 2'd1;
                default: occ_q <= occ_q;
            endcase
        end
    end

    assign bus.fifo_r_enable = rd_en;
    assign bus.out_valid     = out_vld;
    assign bus.out_data      = head_byte;
    assign bus.out_last      = out_vld && (idx_q == LAST_IDX);
    assign word_cnt          = word_cnt_q;
    assign busy              = out_vld || inflight_q;

    a_no_overfill: assert property (@(posedge r_clk) disable iff (r_rst)
        !(capture && !pop && occ_q == 2'd2));
    a_credit_bound: assert property (@(posedge r_clk) disable iff (r_rst)
        pending <= 2'd2);
endmodule

// File: tb/tb_fifo_rd_unpacker.sv
// Randomized bench for fifo_rd_unpacker: a FIFO source plus a queue-based byte-stream reference model.
module tb_fifo_rd_unpacker;
    localparam int DATA_W = 24;
    localparam int CNT_W  = 2;
    localparam int NBYTES = DATA_W / 8;

    logic             r_clk = 1'b0;
    logic             r_rst;
    logic [CNT_W-1:0] word_cnt;
    logic             busy;

    fifo_rd_unpacker_if #(.DATA_W(DATA_W)) bus ();

    fifo_rd_unpacker #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .r_clk    (r_clk),
        .r_rst    (r_rst),
        .bus      (bus),
        .word_cnt (word_cnt),
        .busy     (busy)
    );

    always #5 r_clk = ~r_clk;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] src_q[$];
    bit                src_en;

    // Reference: bytes still owed downstream (words read from the FIFO, in order) and word occupancy.
    logic [7:0] exp_q[$];
    bit         exp_last_q[$];
    int         m_occ;
    bit         m_inflight;
    int         m_words;

    logic             o_vld, o_last, o_ren, o_busy;
    logic [7:0]       o_dat;
    logic [CNT_W-1:0] o_cnt;
    logic             e_vld, e_last, e_ren, e_busy;
    logic [7:0]       e_dat;
    logic [CNT_W-1:0] e_cnt;
    bit               hs;

    // One clock cycle: called at negedge with this cycle's inputs already set.
    task automatic step();
        logic [DATA_W-1:0] w;
        int pos;
        w = DATA_W'($urandom);
        bus.fifo_empty = !(src_en && src_q.size() != 0);
        #1;
        o_vld  = bus.out_valid;
        o_dat  = bus.out_data;
        o_last = bus.out_last;
        o_ren  = bus.fifo_r_enable;
        o_busy = busy;
        o_cnt  = word_cnt;

        e_vld  = (m_occ != 0);
        e_dat  = e_vld ? exp_q[0] : 8'h00;
        e_last = e_vld && exp_last_q[0];
        e_ren  = !r_rst && !bus.fifo_empty && (m_occ + int'(m_inflight) < 2);
        e_busy = e_vld || m_inflight;
        e_cnt  = CNT_W'(m_words);
        hs     = e_vld && bus.out_ready;

        if (r_rst) begin
            m_occ = 0; m_inflight = 0; m_words = 0;
            exp_q.delete(); exp_last_q.delete();
        end else begin
            if (hs) begin
                if (exp_last_q[0]) begin m_occ--; m_words++; end
                void'(exp_q.pop_front());
                void'(exp_last_q.pop_front());
            end
            if (m_inflight) m_occ++;
            m_inflight = o_ren;
            if (o_ren && src_q.size() != 0) begin
                w = src_q.pop_front();
                for (int b = 0; b < NBYTES; b++) begin
`ifdef UNPACKER_MSB_FIRST_EN
                    pos = NBYTES - 1 - b;
`else
                    pos = b;
`endif
                    exp_q.push_back(8'(w >> (8 * pos)));
                    exp_last_q.push_back(b == NBYTES - 1);
                end
            end
        end
        @(posedge r_clk);
        #1;
        bus.fifo_r_data = w;
        @(negedge r_clk);
    endtask

    task automatic do_reset();
        src_q.delete();
        src_en = 1'b1;
        bus.out_ready = 1'b1;
        r_rst = 1'b1;
        step();
        step();
        r_rst = 1'b0;
    endtask

    task automatic test_reset();
        src_q.delete();
        src_q.push_back(24'h123456);
        src_en = 1'b1;
        bus.out_ready = 1'b0;
        r_rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (o_ren !== 1'b0) begin errors++; $display("FAIL reset_ren cyc %0d: got %b want 0", i, o_ren); end
            if (i > 0) begin
                checks++;
                if ({o_vld, o_dat, o_last, o_busy} !== 11'd0 || o_cnt !== '0) begin
                    errors++;
                    $display("FAIL reset_outs cyc %0d: vld=%b dat=%h last=%b busy=%b cnt=%0d want all 0",
                             i, o_vld, o_dat, o_last, o_busy, o_cnt);
                end
            end
        end
    endtask

    task automatic test_single();
        logic [7:0] want [3];
        logic [7:0] got  [3];
        bit         gotl [3];
        int strobes = 0, strb_cyc = -1, first_cyc = -1, nb = 0;
`ifdef UNPACKER_MSB_FIRST_EN
        want = '{8'h0A, 8'h0B, 8'h0C};
`else
        want = '{8'h0C, 8'h0B, 8'h0A};
`endif
        do_reset();
        src_q.push_back(24'h0A0B0C);
        for (int cyc = 0; cyc < 10; cyc++) begin
            step();
            checks++;
            if (o_ren !== e_ren) begin errors++; $display("FAIL single_ren cyc %0d: got %b want %b", cyc, o_ren, e_ren); end
            checks++;
            if (o_vld !== e_vld) begin errors++; $display("FAIL single_vld cyc %0d: got %b want %b", cyc, o_vld, e_vld); end
            checks++;
            if (o_busy !== e_busy) begin errors++; $display("FAIL single_busy cyc %0d: got %b want %b", cyc, o_busy, e_busy); end
            if (o_ren === 1'b1) begin strobes++; strb_cyc = cyc; end
            if (o_vld === 1'b1 && first_cyc < 0) first_cyc = cyc;
            if (hs && nb < 3) begin got[nb] = o_dat; gotl[nb] = o_last; nb++; end
        end
        checks++;
        if (strobes != 1) begin errors++; $display("FAIL single_strobes: got %0d want 1", strobes); end
        checks++;
        if (first_cyc - strb_cyc != 2) begin errors++; $display("FAIL single_latency: got %0d want 2", first_cyc - strb_cyc); end
        checks++;
        if (nb != 3) begin errors++; $display("FAIL single_nbytes: got %0d want 3", nb); end
        for (int i = 0; i < nb; i++) begin
            checks++;
            if (got[i] !== want[i] || gotl[i] !== (i == 2))
                begin errors++; $display("FAIL single_byte%0d: got %h/last=%b want %h/last=%b", i, got[i], gotl[i], want[i], i == 2); end
        end
        checks++;
        if (o_cnt !== CNT_W'(1)) begin errors++; $display("FAIL single_word_cnt: got %0d want 1", o_cnt); end
    endtask

    task automatic test_streaming();
        int bytes = 0;
        bit seen = 0;
        do_reset();
        for (int i = 0; i < 7; i++) src_q.push_back(DATA_W'(i));
        for (int cyc = 0; cyc < 60 && bytes < 21; cyc++) begin
            step();
            if (o_vld === 1'b1) seen = 1;
            if (seen) begin
                checks++;
                if (o_vld !== 1'b1) begin errors++; $display("FAIL stream_gap cyc %0d: out_valid got %b want 1", cyc, o_vld); end
            end
            if (e_vld) begin
                checks++;
                if (o_dat !== e_dat || o_last !== e_last)
                    begin errors++; $display("FAIL stream_data cyc %0d: got %h/%b want %h/%b", cyc, o_dat, o_last, e_dat, e_last); end
            end
            if (hs) bytes++;
        end
        checks++;
        if (bytes != 21) begin errors++; $display("FAIL stream_timeout: got %0d bytes want 21", bytes); end
        step();
        checks++;
        if (o_cnt !== CNT_W'(7) || o_vld !== 1'b0)
            begin errors++; $display("FAIL stream_end: cnt=%0d vld=%b want cnt=%0d vld=0", o_cnt, o_vld, CNT_W'(7)); end
    endtask

    task automatic test_backpressure();
        int bytes = 0;
        bit prev_stall = 0;
        logic [7:0] prev_dat = 8'h00;
        logic prev_last = 1'b0;
        do_reset();
        for (int i = 0; i < 8; i++) src_q.push_back(DATA_W'($urandom));
        for (int cyc = 0; cyc < 300 && bytes < 24; cyc++) begin
            bus.out_ready = (cyc % 3 == 0);
            step();
            checks++;
            if (o_ren !== e_ren) begin errors++; $display("FAIL bp_ren cyc %0d: got %b want %b", cyc, o_ren, e_ren); end
            if (prev_stall) begin
                checks++;
                if (o_vld !== 1'b1 || o_dat !== prev_dat || o_last !== prev_last)
                    begin errors++; $display("FAIL bp_stable cyc %0d: got %h/%b want %h/%b", cyc, o_dat, o_last, prev_dat, prev_last); end
            end
            if (e_vld) begin
                checks++;
                if (o_vld !== 1'b1 || o_dat !== e_dat || o_last !== e_last)
                    begin errors++; $display("FAIL bp_data cyc %0d: got %b/%h/%b want 1/%h/%b", cyc, o_vld, o_dat, o_last, e_dat, e_last); end
            end
            prev_stall = o_vld && !bus.out_ready;
            prev_dat = o_dat;
            prev_last = o_last;
            if (hs) bytes++;
        end
        checks++;
        if (bytes != 24) begin errors++; $display("FAIL bp_timeout: got %0d bytes want 24", bytes); end
        bus.out_ready = 1'b1;
        step();
        checks++;
        if (o_cnt !== CNT_W'(8)) begin errors++; $display("FAIL bp_word_cnt: got %0d want %0d", o_cnt, CNT_W'(8)); end
    endtask

    task automatic test_reset_mid_word();
        bit done = 0;
        do_reset();
        src_q.push_back(24'h112233);
        src_q.push_back(24'h778899);
        for (int cyc = 0; cyc < 20 && !done; cyc++) begin
            step();
            if (hs) begin
                done = 1;
                checks++;
                if (o_dat !== e_dat) begin errors++; $display("FAIL midrst_first: got %h want %h", o_dat, e_dat); end
            end
        end
        checks++;
        if (!done) begin errors++; $display("FAIL midrst_timeout: no first byte, got 0 want 1"); end
        src_q.delete();
        r_rst = 1'b1;
        step();
        r_rst = 1'b0;
        step();
        checks++;
        if (o_vld !== 1'b0 || o_busy !== 1'b0)
            begin errors++; $display("FAIL midrst_after: vld=%b busy=%b want 0/0", o_vld, o_busy); end
        src_q.push_back(24'h445566);
        done = 0;
        for (int cyc = 0; cyc < 20 && !done; cyc++) begin
            step();
            if (hs) begin
                done = 1;
                checks++;
`ifdef UNPACKER_MSB_FIRST_EN
                if (o_dat !== 8'h44) begin errors++; $display("FAIL midrst_restart: got %h want 44", o_dat); end
`else
                if (o_dat !== 8'h66) begin errors++; $display("FAIL midrst_restart: got %h want 66", o_dat); end
`endif
            end
        end
        checks++;
        if (!done) begin errors++; $display("FAIL midrst_timeout2: no byte after reset, got 0 want 1"); end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 5; i++) src_q.push_back(DATA_W'($urandom));
        for (int cyc = 0; cyc < 40 && m_words < 5; cyc++) step();
        step();
        checks++;
        if (o_cnt !== CNT_W'(1)) begin errors++; $display("FAIL wrap_word_cnt: got %0d want 1", o_cnt); end
    endtask

    task automatic test_random();
        int bytes = 0;
        do_reset();
        for (int i = 0; i < 30; i++) src_q.push_back(DATA_W'($urandom));
        for (int cyc = 0; cyc < 800 && bytes < 90; cyc++) begin
            src_en = ($urandom_range(3) != 0);
            bus.out_ready = $urandom_range(1);
            step();
            checks++;
            if (o_ren !== e_ren || o_vld !== e_vld || o_busy !== e_busy || o_cnt !== e_cnt)
                begin errors++; $display("FAIL rand_ctrl cyc %0d: ren/vld/busy/cnt got %b%b%b/%0d want %b%b%b/%0d",
                                         cyc, o_ren, o_vld, o_busy, o_cnt, e_ren, e_vld, e_busy, e_cnt); end
            if (e_vld) begin
                checks++;
                if (o_dat !== e_dat || o_last !== e_last)
                    begin errors++; $display("FAIL rand_data cyc %0d: got %h/%b want %h/%b", cyc, o_dat, o_last, e_dat, e_last); end
            end
            if (hs) bytes++;
        end
        checks++;
        if (bytes != 90) begin errors++; $display("FAIL rand_timeout: got %0d bytes want 90", bytes); end
    endtask

    initial begin
        r_rst = 1'b1;
        src_en = 1'b0;
        bus.fifo_empty = 1'b1;
        bus.out_ready = 1'b0;
        bus.fifo_r_data = '0;
        m_occ = 0; m_inflight = 0; m_words = 0;
        @(negedge r_clk);
        test_reset();
        test_single();
        test_streaming();
        test_backpressure();
        test_reset_mid_word();
        test_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
